rv32_fetch_stage: RTL and testbench



---
 rtl/rv32_types_pkg.sv | 13 +
 rtl/rv32_fetch_fifo.sv | 58 +++++
 rtl/rv32_fetch_stage.sv | 145 ++++++++++++++
 tb/tb_rv32_fetch_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_types_pkg.sv
// Shared RV32 fetch types: instruction word, NOP encoding and the {pc, instr} entry
// carried by the fetch queues.
package rv32_types_pkg;
    typedef logic [31:0] rv_instr_t;

    localparam rv_instr_t NOP_INSTR       = 32'h0000_0013;
    localparam int        FETCH_BUF_DEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        rv_instr_t   instr;
    } fetch_entry_t;
endpackage

// File: rtl/rv32_fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush; used both as the in-flight PC
// queue and as the response buffer in front of decode.
module rv32_fetch_fifo
    import rv32_types_pkg::*;
#(
    parameter int DEPTH = FETCH_BUF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW:0]    count_reg;
    logic           do_push;
    logic           do_pop;

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_pop  = pop && (count_reg != '0);
    assign do_push = push && ((count_reg != (AW+1)'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;
endmodule

// File: rtl/rv32_fetch_stage.sv
// RV32 instruction fetch stage: owns the PC, bounds outstanding requests by free buffer
// space, flushes on redirect. Optional RV32_FETCH_MISALIGN_CHECK_EN flags misaligned targets.
module rv32_fetch_stage
    import rv32_types_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = FETCH_BUF_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        fetch_valid,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc,
    input  logic        decode_ready,
    output logic        fetch_misaligned
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    logic [31:0]   pc_reg, pc_next;
    logic [CW-1:0] outstanding_reg, outstanding_next;
    logic [CW-1:0] drop_reg, drop_next;
    logic [CW-1:0] pcq_count, buf_count;
    logic [CW:0]   occupancy;
    fetch_entry_t  pcq_push_data, pcq_head, rsp_entry, buf_head;
    logic          req_fire, rsp_keep, buf_valid, buf_pop;
    logic          misalign_halt, misalign_pend;
    logic          pcq_instr_unused;

    // Outstanding requests reserve buffer slots, so a response never finds the buffer full.
    assign occupancy      = {1'b0, outstanding_reg} + {1'b0, buf_count};
    assign imem_req_valid = !rst && !misalign_halt && (occupancy < (CW+1)'(BUF_DEPTH));
    assign imem_req_addr  = pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && (drop_reg == '0);

    assign pcq_push_data    = '{pc: pc_reg, instr: NOP_INSTR};
    assign rsp_entry        = '{pc: pcq_head.pc, instr: imem_rsp_data};
    assign pcq_instr_unused = ^pcq_head.instr;

    rv32_fetch_fifo #(.DEPTH(BUF_DEPTH)) u_pc_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (req_fire),
        .push_data (pcq_push_data),
        .pop       (rsp_keep),
        .head      (pcq_head),
        .count     (pcq_count)
    );

    rv32_fetch_fifo #(.DEPTH(BUF_DEPTH)) u_rsp_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (rsp_keep),
        .push_data (rsp_entry),
        .pop       (buf_pop),
        .head      (buf_head),
        .count     (buf_count)
    );

    always_comb begin
        pc_next          = pc_reg;
        outstanding_next = outstanding_reg + CW'(req_fire) - CW'(imem_rsp_valid);
        drop_next        = drop_reg;
        if (req_fire) begin
            pc_next = pc_reg + 32'd4;
        end
        if (imem_rsp_valid && (drop_reg != '0)) begin
            drop_next = drop_reg - CW'(1);
        end
        // Everything still in flight after this cycle belongs to the abandoned path.
        if (redirect_valid) begin
            pc_next   = {redirect_target[31:2], 2'b00};
            drop_next = outstanding_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg          <= RESET_PC;
            outstanding_reg <= '0;
            drop_reg        <= '0;
        end else begin
            pc_reg          <= pc_next;
            outstanding_reg <= outstanding_next;
            drop_reg        <= drop_next;
        end
    end

`ifdef RV32_FETCH_MISALIGN_CHECK_EN
    logic halt_reg, pend_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_reg <= 1'b0;
            pend_reg <= 1'b0;
        end else if (redirect_valid) begin
            halt_reg <= |redirect_target[1:0];
            pend_reg <= |redirect_target[1:0];
        end else if (pend_reg && decode_ready) begin
            pend_reg <= 1'b0;
        end
    end

    assign misalign_halt = halt_reg;
    assign misalign_pend = pend_reg;
`else
    logic target_low_unused;
    assign target_low_unused = |redirect_target[1:0];
    assign misalign_halt     = 1'b0;
    assign misalign_pend     = 1'b0;
`endif

    assign buf_valid = (buf_count != '0);
    assign buf_pop   = buf_valid && decode_ready && !misalign_pend;

    always_comb begin
        fetch_valid      = buf_valid;
        fetch_pc         = RESET_PC;
        fetch_instr      = NOP_INSTR;
        fetch_misaligned = 1'b0;
        if (misalign_pend) begin
            fetch_valid      = 1'b1;
            fetch_pc         = pc_reg;
            fetch_misaligned = 1'b1;
        end else if (buf_valid) begin
            fetch_pc    = buf_head.pc;
            fetch_instr = buf_head.instr;
        end
    end

    rsp_needs_outstanding: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (outstanding_reg != '0));

    pcq_tracks_outstanding: assert property (@(posedge clk) disable iff (rst)
        ({1'b0, pcq_count} + {1'b0, drop_reg}) == {1'b0, outstanding_reg});
endmodule

// File: tb/tb_rv32_fetch_stage.sv
// Scoreboard bench for rv32_fetch_stage: a memory model answers requests with an
// address-derived word; the expected stream is the sequential program path from each redirect.
module tb_rv32_fetch_stage;
    import rv32_types_pkg::*;

    localparam int          BUF_DEPTH = 2;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    logic        clk, rst;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_req_addr, imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        fetch_valid, decode_ready, fetch_misaligned;
    logic [31:0] fetch_instr, fetch_pc;

    rv32_fetch_stage #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_valid   (imem_req_valid),
        .imem_req_addr    (imem_req_addr),
        .imem_req_ready   (imem_req_ready),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .fetch_valid      (fetch_valid),
        .fetch_instr      (fetch_instr),
        .fetch_pc         (fetch_pc),
        .decode_ready     (decode_ready),
        .fetch_misaligned (fetch_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; logic mis; } exp_t;

    req_t        pend[$];
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] tail_pc, last_req_addr;
    bit          halted, saw_wrap, chk_after_redir, exp_after_redir;
    int          cyc, lat, pct_rdy, pct_dec, pct_redir, first_valid;
    int          errors, checks, fires;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = ($urandom_range(3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F)) : ($urandom & 32'h0000_3FFF);
`ifdef RV32_FETCH_MISALIGN_CHECK_EN
        t[1:0] = 2'b00;
`endif
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic topup();
        if (!halted) begin
            while (exp_q.size() < 8) begin
                exp_q.push_back('{pc: tail_pc, instr: mem_word(tail_pc), mis: 1'b0});
                tail_pc = tail_pc + 32'd4;
            end
        end
    endtask

    task automatic apply_redirect(input logic [31:0] t);
        exp_q.delete();
        tail_pc         = {t[31:2], 2'b00};
        halted          = 1'b0;
        exp_after_redir = 1'b0;
`ifdef RV32_FETCH_MISALIGN_CHECK_EN
        if (t[1:0] != 2'b00) begin
            exp_q.push_back('{pc: tail_pc, instr: NOP_INSTR, mis: 1'b1});
            halted          = 1'b1;
            exp_after_redir = 1'b1;
        end
`endif
    endtask

    task automatic drive_inputs(input bit force_redir, input logic [31:0] tgt);
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        imem_req_ready  = ($urandom_range(99) < pct_rdy);
        decode_ready    = ($urandom_range(99) < pct_dec);
        redirect_valid  = force_redir || ($urandom_range(99) < pct_redir);
        redirect_target = force_redir ? tgt : rand_target();
    endtask

    // One clock of memory model and stimulus; inputs change #1 after the rising edge.
    task automatic step(input bit force_redir, input logic [31:0] tgt);
        bit          redir_seen;
        logic [31:0] redir_tgt;
        @(negedge clk);
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr_aligned", {30'd0, imem_req_addr[1:0]}, 32'd0);
            if (imem_req_addr == 32'h0 && last_req_addr == 32'hFFFF_FFFC) saw_wrap = 1'b1;
            last_req_addr = imem_req_addr;
            pend.push_back('{addr: imem_req_addr, due: cyc + lat});
        end
        if (imem_rsp_valid) void'(pend.pop_front());
        check("outstanding_le_depth", {31'd0, pend.size() <= BUF_DEPTH}, 32'd1);
        if (chk_after_redir) check("valid_after_redirect", {31'd0, fetch_valid}, {31'd0, exp_after_redir});
        chk_after_redir = 1'b0;
        if (fetch_valid && first_valid < 0) first_valid = cyc;
        redir_seen = redirect_valid;
        redir_tgt  = redirect_target;
        @(posedge clk);
        #1;
        cyc++;
        if (redir_seen) begin
            apply_redirect(redir_tgt);
            chk_after_redir = 1'b1;
        end
        topup();
        drive_inputs(force_redir, tgt);
    endtask

    task automatic do_reset(input int cycles);
        rst             = 1'b1;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = 32'd0;
        imem_req_ready  = 1'b0;
        decode_ready    = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        pend.delete();
        exp_q.delete();
        tail_pc         = RESET_PC;
        halted          = 1'b0;
        chk_after_redir = 1'b0;
        last_req_addr   = 32'h1;
        #1;
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        check("rst_fetch_instr", fetch_instr, NOP_INSTR);
        check("rst_fetch_pc", fetch_pc, RESET_PC);
        check("rst_fetch_misaligned", {31'd0, fetch_misaligned}, 32'd0);
        repeat (cycles) @(posedge clk);
        #1;
        rst         = 1'b0;
        cyc         = 0;
        first_valid = -1;
        topup();
        drive_inputs(1'b0, 32'd0);
    endtask

    // Monitor: every decode handshake must match the head of the expected stream.
    always @(negedge clk) begin
        if (!rst) begin
            if (fetch_valid && decode_ready) begin
                fires++;
                $display("fetch pc=%h instr=%h mis=%0d", fetch_pc, fetch_instr, fetch_misaligned);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_fetch: got pc %h, expected no entry", fetch_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("fetch_pc", fetch_pc, mon_e.pc);
                    check("fetch_instr", fetch_instr, mon_e.instr);
                    check("fetch_misaligned", {31'd0, fetch_misaligned}, {31'd0, mon_e.mis});
                end
            end else if (!fetch_valid) begin
                check("idle_instr_nop", fetch_instr, NOP_INSTR);
            end
        end
    end

    initial begin
        errors = 0; checks = 0; fires = 0; saw_wrap = 1'b0; cyc = 0;
        lat = 1; pct_rdy = 100; pct_dec = 100; pct_redir = 0;
        do_reset(3);
        repeat (12) step(1'b0, 32'd0);
        check("first_valid_cycle", first_valid, 32'd2);

        pct_dec = 0;
        repeat (10) step(1'b0, 32'd0);
        check("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("stall_fetch_valid", {31'd0, fetch_valid}, 32'd1);
        pct_dec = 100;
        repeat (10) step(1'b0, 32'd0);

        lat = 3;
        repeat (8) step(1'b0, 32'd0);
        step(1'b1, 32'h0000_0100);
        repeat (12) step(1'b0, 32'd0);

        lat = 1;
        for (int i = 0; i < 6; i++) begin
            repeat (i) step(1'b0, 32'd0);
            step(1'b1, 32'h0000_0400 + 32'(i * 64));
        end
        repeat (8) step(1'b0, 32'd0);

        step(1'b1, 32'hFFFF_FFF4);
        repeat (12) step(1'b0, 32'd0);
        check("pc_wrap_request", {31'd0, saw_wrap}, 32'd1);

`ifdef RV32_FETCH_MISALIGN_CHECK_EN
        lat = 2; pct_dec = 0;
        step(1'b1, 32'h0000_0102);
        repeat (5) step(1'b0, 32'd0);
        check("mis_fetch_valid", {31'd0, fetch_valid}, 32'd1);
        check("mis_flag", {31'd0, fetch_misaligned}, 32'd1);
        check("mis_fetch_pc", fetch_pc, 32'h0000_0100);
        check("mis_halt_req", {31'd0, imem_req_valid}, 32'd0);
        pct_dec = 100;
        repeat (4) step(1'b0, 32'd0);
        check("mis_still_halted", {31'd0, imem_req_valid}, 32'd0);
        step(1'b1, 32'h0000_0200);
        repeat (12) step(1'b0, 32'd0);
`else
        step(1'b1, 32'h0000_0206);
        repeat (8) step(1'b0, 32'd0);
`endif

        for (int blk = 0; blk < 16; blk++) begin
            lat       = 1 + int'($urandom_range(3));
            pct_rdy   = 30 + int'($urandom_range(70));
            pct_dec   = 20 + int'($urandom_range(80));
            pct_redir = (blk % 4 == 3) ? 0 : 3;
            repeat (100) step(1'b0, 32'd0);
            if (blk == 8) do_reset(2);
        end
        pct_redir = 0; pct_dec = 100; pct_rdy = 100;
        repeat (30) step(1'b0, 32'd0);
        check("fires_seen", {31'd0, fires >= 200}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
